if_stage_fetch: RTL and testbench

Instruction fetch stage of the forwarding/stall pipelined CPU. It owns the PC, drives the word address into the instruction ROM, and captures the returned instruction into the IF/ID pipeline register. It honours ID-stage stall requests (load-use hazards) and ID-resolved branch redirects, inserting a single-cycle bubble on a taken branch. It also keeps a saturating count of valid fetched instructions for debug.

---
 rtl/if_stage_fetch.sv | 80 ++++++++
 tb/tb_if_stage_fetch.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/if_stage_fetch.sv
// Fetch stage: owns the PC, addresses the async ROM and registers IF/ID one edge after fetch.
// A stall freezes all state; a taken branch redirects the PC and leaves one bubble in IF/ID.
module if_stage_fetch #(
  parameter int              PC_W     = 32,
  parameter int              ADDR_W   = 6,
  parameter int              CNT_W    = 16,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              branch_taken,
  input  logic [PC_W-1:0]   branch_target,
  input  logic [31:0]       rom_inst,
  output logic [ADDR_W-1:0] rom_addr,
  output logic [PC_W-1:0]   pc,
  output logic [31:0]       if_id_inst,
  output logic [PC_W-1:0]   if_id_pc4,
  output logic              if_id_valid,
  output logic [CNT_W-1:0]  fetch_cnt
);

  logic [PC_W-1:0]  pc_q,    pc_d;
  logic [31:0]      inst_q,  inst_d;
  logic [PC_W-1:0]  pc4_q,   pc4_d;
  logic             valid_q, valid_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;
  logic [PC_W-1:0]  pc_plus4;

  assign pc_plus4 = pc_q + PC_W'(4);

  always_comb begin
    pc_d    = pc_q;
    inst_d  = inst_q;
    pc4_d   = pc4_q;
    valid_d = valid_q;
    cnt_d   = cnt_q;
    // A stalled branch may have stale operands; ID re-presents it once the stall drops.
    if (!stall) begin
      if (branch_taken) begin
        pc_d    = branch_target & ~PC_W'(3);
        inst_d  = 32'h0;
        pc4_d   = '0;
        valid_d = 1'b0;
      end else begin
        pc_d    = pc_plus4;
        inst_d  = rom_inst;
        pc4_d   = pc_plus4;
        valid_d = 1'b1;
        if (!(&cnt_q)) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q    <= RESET_PC;
      inst_q  <= 32'h0;
      pc4_q   <= '0;
      valid_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      pc_q    <= pc_d;
      inst_q  <= inst_d;
      pc4_q   <= pc4_d;
      valid_q <= valid_d;
      cnt_q   <= cnt_d;
    end
  end

  assign rom_addr    = pc_q[ADDR_W+1:2];
  assign pc          = pc_q;
  assign if_id_inst  = inst_q;
  assign if_id_pc4   = pc4_q;
  assign if_id_valid = valid_q;
  assign fetch_cnt   = cnt_q;

endmodule

// File: tb/tb_if_stage_fetch.sv
// Bench for if_stage_fetch: a behavioural model pushes expected state per edge, popped and compared after it.
module tb_if_stage_fetch;
  localparam int CNT_W = 4;

  typedef struct packed {
    logic [31:0]      pc;
    logic [31:0]      inst;
    logic [31:0]      pc4;
    logic             valid;
    logic [CNT_W-1:0] cnt;
  } obs_t;

  logic             clk = 1'b0;
  logic             rst, stall, branch_taken;
  logic [31:0]      branch_target, rom_inst;
  logic [5:0]       rom_addr;
  logic [31:0]      pc, if_id_inst, if_id_pc4;
  logic             if_id_valid;
  logic [CNT_W-1:0] fetch_cnt;

  logic [31:0] rom [64];
  obs_t        m, exp_s, hold, obs_now;
  obs_t        sb [$];
  int          tests_run = 0;
  int          tests_failed = 0;
  logic [CNT_W-1:0] cnt_before;

  if_stage_fetch #(.PC_W(32), .ADDR_W(6), .CNT_W(CNT_W), .RESET_PC(32'h0)) dut (
    .clk(clk), .rst(rst), .stall(stall), .branch_taken(branch_taken),
    .branch_target(branch_target), .rom_inst(rom_inst), .rom_addr(rom_addr),
    .pc(pc), .if_id_inst(if_id_inst), .if_id_pc4(if_id_pc4),
    .if_id_valid(if_id_valid), .fetch_cnt(fetch_cnt)
  );

  always #5 clk = ~clk;
  assign rom_inst = rom[rom_addr];
  assign obs_now  = {pc, if_id_inst, if_id_pc4, if_id_valid, fetch_cnt};

  // Drive one cycle of inputs, advance the model, queue its prediction, then step past the edge.
  task automatic drive(input logic r, input logic s, input logic b, input logic [31:0] t);
    rst = r; stall = s; branch_taken = b; branch_target = t;
    if (r) begin
      m = '0;
    end else if (!s) begin
      if (b) begin
        m.pc = {t[31:2], 2'b00}; m.inst = 32'h0; m.pc4 = 32'h0; m.valid = 1'b0;
      end else begin
        m.inst = rom[m.pc[7:2]]; m.pc = m.pc + 32'd4; m.pc4 = m.pc; m.valid = 1'b1;
        if (m.cnt != {CNT_W{1'b1}}) m.cnt = m.cnt + 1'b1;
      end
    end
    sb.push_back(m);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 2; i++) begin
      drive(1, 0, 0, 0);
      exp_s = sb.pop_front(); tests_run++;
      if (obs_now !== exp_s) begin tests_failed++; $display("FAIL reset_hold: got %h want %h", obs_now, exp_s); end
    end
    tests_run++;
    if (rom_addr !== 6'h0 || pc !== 32'h0 || if_id_valid !== 1'b0 || fetch_cnt !== '0) begin
      tests_failed++; $display("FAIL reset_vals: rom_addr=%h pc=%h valid=%b cnt=%h want 0/0/0/0", rom_addr, pc, if_id_valid, fetch_cnt);
    end
    drive(0, 0, 0, 0);
    exp_s = sb.pop_front(); tests_run++;
    if (obs_now !== exp_s) begin tests_failed++; $display("FAIL reset_edge1: got %h want %h", obs_now, exp_s); end
    tests_run++;
    if (pc !== 32'h4 || if_id_inst !== 32'h0 || if_id_valid !== 1'b1) begin
      tests_failed++; $display("FAIL reset_edge1_const: pc=%h inst=%h valid=%b want 4/0/1", pc, if_id_inst, if_id_valid);
    end
    drive(0, 0, 0, 0);
    exp_s = sb.pop_front(); tests_run++;
    if (obs_now !== exp_s) begin tests_failed++; $display("FAIL reset_edge2: got %h want %h", obs_now, exp_s); end
    tests_run++;
    if (if_id_inst !== 32'h00100c22 || if_id_pc4 !== 32'h8 || pc !== 32'h8 || fetch_cnt !== 4'd2) begin
      tests_failed++; $display("FAIL reset_edge2_const: inst=%h pc4=%h pc=%h cnt=%0d want 00100c22/8/8/2", if_id_inst, if_id_pc4, pc, fetch_cnt);
    end
  endtask

  task automatic test_stall();
    for (int i = 0; i < 2; i++) begin
      drive(0, 0, 0, 0);
      exp_s = sb.pop_front(); tests_run++;
      if (obs_now !== exp_s) begin tests_failed++; $display("FAIL stall_walk: got %h want %h", obs_now, exp_s); end
    end
    tests_run++;
    if (pc !== 32'h10 || rom_addr !== 6'd4) begin
      tests_failed++; $display("FAIL stall_setup: pc=%h rom_addr=%h want 10/4", pc, rom_addr);
    end
    hold = obs_now;
    for (int i = 0; i < 3; i++) begin
      drive(0, 1, 0, 0);
      exp_s = sb.pop_front(); tests_run++;
      if (obs_now !== exp_s || obs_now !== hold) begin
        tests_failed++; $display("FAIL stall_hold: got %h want %h", obs_now, exp_s);
      end
    end
    drive(0, 0, 0, 0);
    exp_s = sb.pop_front(); tests_run++;
    if (obs_now !== exp_s || if_id_inst !== 32'h34000826 || if_id_pc4 !== 32'h14) begin
      tests_failed++; $display("FAIL stall_release: got %h want %h", obs_now, exp_s);
    end
  endtask

  task automatic test_branch();
    drive(0, 0, 1, 32'h40);
    exp_s = sb.pop_front(); tests_run++;
    if (obs_now !== exp_s) begin tests_failed++; $display("FAIL branch_setup: got %h want %h", obs_now, exp_s); end
    cnt_before = fetch_cnt;
    drive(0, 0, 1, 32'h10);
    exp_s = sb.pop_front(); tests_run++;
    if (obs_now !== exp_s) begin tests_failed++; $display("FAIL branch_redirect: got %h want %h", obs_now, exp_s); end
    tests_run++;
    if (pc !== 32'h10 || if_id_inst !== 32'h0 || if_id_valid !== 1'b0 || fetch_cnt !== cnt_before) begin
      tests_failed++; $display("FAIL branch_flush: pc=%h inst=%h valid=%b cnt=%0d want 10/0/0/%0d", pc, if_id_inst, if_id_valid, fetch_cnt, cnt_before);
    end
    drive(0, 0, 0, 0);
    exp_s = sb.pop_front(); tests_run++;
    if (obs_now !== exp_s || if_id_inst !== 32'h34000826 || if_id_valid !== 1'b1) begin
      tests_failed++; $display("FAIL branch_resume: got %h want %h", obs_now, exp_s);
    end
  endtask

  task automatic test_stall_branch();
    drive(0, 0, 1, 32'h40);
    exp_s = sb.pop_front(); tests_run++;
    if (obs_now !== exp_s) begin tests_failed++; $display("FAIL sb_setup: got %h want %h", obs_now, exp_s); end
    hold = obs_now;
    drive(0, 1, 1, 32'h10);
    exp_s = sb.pop_front(); tests_run++;
    if (obs_now !== exp_s || obs_now !== hold || pc !== 32'h40) begin
      tests_failed++; $display("FAIL sb_hold: got %h want %h", obs_now, exp_s);
    end
    drive(0, 0, 1, 32'h10);
    exp_s = sb.pop_front(); tests_run++;
    if (obs_now !== exp_s || pc !== 32'h10) begin
      tests_failed++; $display("FAIL sb_redirect: got %h want %h", obs_now, exp_s);
    end
  endtask

  task automatic test_misalign_wrap();
    drive(0, 0, 1, 32'h13);
    exp_s = sb.pop_front(); tests_run++;
    if (obs_now !== exp_s || pc !== 32'h10) begin
      tests_failed++; $display("FAIL misalign: got %h want %h", obs_now, exp_s);
    end
    drive(0, 0, 1, 32'hFC);
    exp_s = sb.pop_front(); tests_run++;
    if (obs_now !== exp_s || rom_addr !== 6'h3F) begin
      tests_failed++; $display("FAIL rom_top: got %h want %h rom_addr=%h", obs_now, exp_s, rom_addr);
    end
    drive(0, 0, 0, 0);
    exp_s = sb.pop_front(); tests_run++;
    if (obs_now !== exp_s || pc !== 32'h100 || rom_addr !== 6'h0 || if_id_inst !== 32'hDEADBEEF) begin
      tests_failed++; $display("FAIL rom_wrap: got %h want %h rom_addr=%h", obs_now, exp_s, rom_addr);
    end
    drive(0, 0, 1, 32'hFFFF_FFFF);
    exp_s = sb.pop_front(); tests_run++;
    if (obs_now !== exp_s || pc !== 32'hFFFF_FFFC) begin
      tests_failed++; $display("FAIL pc_top: got %h want %h", obs_now, exp_s);
    end
    drive(0, 0, 0, 0);
    exp_s = sb.pop_front(); tests_run++;
    if (obs_now !== exp_s || pc !== 32'h0 || if_id_pc4 !== 32'h0 || if_id_valid !== 1'b1) begin
      tests_failed++; $display("FAIL pc_wrap: got %h want %h", obs_now, exp_s);
    end
  endtask

  task automatic test_saturate();
    for (int i = 0; i < 20; i++) begin
      drive(0, 0, 0, 0);
      exp_s = sb.pop_front(); tests_run++;
      if (obs_now !== exp_s) begin tests_failed++; $display("FAIL sat_walk%0d: got %h want %h", i, obs_now, exp_s); end
    end
    tests_run++;
    if (fetch_cnt !== {CNT_W{1'b1}}) begin
      tests_failed++; $display("FAIL sat_cnt: got %h want %h", fetch_cnt, {CNT_W{1'b1}});
    end
  endtask

  task automatic test_reset_mid();
    drive(0, 0, 1, 32'h24);
    exp_s = sb.pop_front(); tests_run++;
    if (obs_now !== exp_s || pc !== 32'h24) begin tests_failed++; $display("FAIL mid_setup: got %h want %h", obs_now, exp_s); end
    drive(0, 1, 0, 0);
    exp_s = sb.pop_front(); tests_run++;
    if (obs_now !== exp_s) begin tests_failed++; $display("FAIL mid_stall: got %h want %h", obs_now, exp_s); end
    drive(1, 1, 0, 0);
    exp_s = sb.pop_front(); tests_run++;
    if (obs_now !== exp_s || obs_now !== '0) begin
      tests_failed++; $display("FAIL mid_reset_stall: got %h want %h", obs_now, exp_s);
    end
    drive(0, 0, 0, 0);
    exp_s = sb.pop_front(); tests_run++;
    if (obs_now !== exp_s) begin tests_failed++; $display("FAIL mid_run: got %h want %h", obs_now, exp_s); end
    drive(1, 0, 1, 32'h40);
    exp_s = sb.pop_front(); tests_run++;
    if (obs_now !== exp_s || obs_now !== '0) begin
      tests_failed++; $display("FAIL mid_reset_branch: got %h want %h", obs_now, exp_s);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 64; i++) rom[i] = 32'hA5000000 | (i * 32'h00010101);
    rom[0]  = 32'h00000000;
    rom[1]  = 32'h00100c22;
    rom[4]  = 32'h34000826;
    rom[63] = 32'hDEADBEEF;
    rst = 1'b1; stall = 1'b0; branch_taken = 1'b0; branch_target = 32'h0;
    m = '0;
    test_reset();
    test_stall();
    test_branch();
    test_stall_branch();
    test_misalign_wrap();
    test_saturate();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
